// File: rtl/axis_load_sweep_ctrl.sv
// Load-sweep sequencer: steps the NoC traffic harness through a table of offered loads.
// Define AXIS_LOAD_SWEEP_ABORT_ON_ERROR_EN to end the sweep after the first errored point.
module axis_load_sweep_ctrl #(
  parameter int unsigned NUM_TG        = 4,
  parameter int unsigned NUM_LOADS     = 13,
  parameter int unsigned LOAD_WIDTH    = 16,
  parameter int unsigned COUNT_WIDTH   = 32,
  parameter int unsigned RESET_CYCLES  = 6,
  parameter int unsigned SETTLE_CYCLES = 5,
  parameter int unsigned ARM_CYCLES    = 6,
  parameter int unsigned DRAIN_CYCLES  = 3,
  parameter int unsigned TIMEOUT_WIDTH = 31
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sweep_start,
  input  logic [NUM_LOADS*LOAD_WIDTH-1:0] load_table,
  input  logic [NUM_TG-1:0]               tg_done,
  input  logic [NUM_TG-1:0]               chk_error,
  input  logic [COUNT_WIDTH-1:0]          sum_sent,
  input  logic [COUNT_WIDTH-1:0]          sum_recv,
  output logic                            harness_rst_n,
  output logic [LOAD_WIDTH-1:0]           load,
  output logic [NUM_TG-1:0]               tg_start,
  output logic [$clog2(NUM_LOADS)-1:0]    load_idx,
  output logic                            point_valid,
  output logic                            point_timeout,
  output logic [NUM_TG-1:0]               point_error,
  output logic [TIMEOUT_WIDTH:0]          run_cycles,
  output logic                            busy,
  output logic                            sweep_done
);

  localparam int unsigned IdxW = $clog2(NUM_LOADS);
  localparam int unsigned CntW = TIMEOUT_WIDTH + 1;

  localparam logic [CntW-1:0] RstInit    = CntW'(RESET_CYCLES - 1);
  localparam logic [CntW-1:0] SettleInit = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] ArmLast    = CntW'(ARM_CYCLES - 1);
  localparam logic [CntW-1:0] DrainInit  = CntW'(DRAIN_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLim = {1'b1, {TIMEOUT_WIDTH{1'b0}}};
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(NUM_LOADS - 1);

  typedef enum logic [2:0] {
    StIdle, StRst, StSettle, StArm, StRun, StDrain, StReport, StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [LOAD_WIDTH-1:0]  load_q, load_d;
  logic [NUM_TG-1:0]      tg_q, tg_d;
  logic                   hrst_q, hrst_d;
  logic                   pv_q, pv_d;
  logic                   pto_q, pto_d;
  logic [NUM_TG-1:0]      perr_q, perr_d;
  logic [CntW-1:0]        runc_q, runc_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NUM_TG-1:0]      err_acc_q, err_acc_d;
  logic                   to_pend_q, to_pend_d;
  logic [CntW-1:0]        runc_pend_q, runc_pend_d;

  logic [LOAD_WIDTH-1:0]  table_entry [NUM_LOADS];
  logic [CntW-1:0]        run_inc;
  logic [IdxW-1:0]        idx_inc;
  logic                   complete;
  logic                   abort;

  for (genvar k = 0; k < NUM_LOADS; k++) begin : g_table
    assign table_entry[k] = load_table[k*LOAD_WIDTH +: LOAD_WIDTH];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    load_d      = load_q;
    tg_d        = tg_q;
    pto_d       = pto_q;
    perr_d      = perr_q;
    runc_d      = runc_q;
    err_acc_d   = err_acc_q;
    to_pend_d   = to_pend_q;
    runc_pend_d = runc_pend_q;

    // cnt counts ARM+RUN cycles upward; this is the count including the current cycle
    run_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    idx_inc  = idx_q + 1'b1;
    complete = (&tg_done) && (sum_sent == sum_recv);
`ifdef AXIS_LOAD_SWEEP_ABORT_ON_ERROR_EN
    abort = |perr_q;
`else
    abort = 1'b0;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (sweep_start) begin
          state_d = StRst;
          cnt_d   = RstInit;
          idx_d   = '0;
          load_d  = table_entry[0];
        end
      end
      StRst: begin
        if (cnt_q == '0) begin
          state_d = StSettle;
          cnt_d   = SettleInit;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d   = StArm;
          cnt_d     = '0;
          tg_d      = '1;
          err_acc_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StArm: begin
        cnt_d     = run_inc;
        err_acc_d = err_acc_q | chk_error;
        if (cnt_q == ArmLast) state_d = StRun;
      end
      StRun: begin
        err_acc_d = err_acc_q | chk_error;
        tg_d      = tg_q & ~tg_done;
        if (complete) begin
          state_d     = StDrain;
          cnt_d       = DrainInit;
          to_pend_d   = 1'b0;
          runc_pend_d = run_inc;
        end else if (run_inc >= TimeoutLim) begin
          state_d     = StDrain;
          cnt_d       = DrainInit;
          to_pend_d   = 1'b1;
          runc_pend_d = run_inc;
        end else begin
          cnt_d = run_inc;
        end
      end
      StDrain: begin
        err_acc_d = err_acc_q | chk_error;
        if (cnt_q == '0) begin
          state_d = StReport;
          pto_d   = to_pend_q;
          perr_d  = err_acc_q | chk_error;
          runc_d  = runc_pend_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StReport: begin
        tg_d = '0;
        if (idx_q == LastIdx || abort) begin
          state_d = StDone;
        end else begin
          state_d = StRst;
          cnt_d   = RstInit;
          idx_d   = idx_inc;
          load_d  = table_entry[idx_inc];
        end
      end
      default: state_d = StIdle;
    endcase

    hrst_d = (state_d == StSettle) || (state_d == StArm) || (state_d == StRun) ||
             (state_d == StDrain) || (state_d == StReport);
    busy_d = (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);
    pv_d   = (state_d == StReport);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      load_q      <= '0;
      tg_q        <= '0;
      hrst_q      <= 1'b0;
      pv_q        <= 1'b0;
      pto_q       <= 1'b0;
      perr_q      <= '0;
      runc_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_acc_q   <= '0;
      to_pend_q   <= 1'b0;
      runc_pend_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      load_q      <= load_d;
      tg_q        <= tg_d;
      hrst_q      <= hrst_d;
      pv_q        <= pv_d;
      pto_q       <= pto_d;
      perr_q      <= perr_d;
      runc_q      <= runc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_acc_q   <= err_acc_d;
      to_pend_q   <= to_pend_d;
      runc_pend_q <= runc_pend_d;
    end
  end

  assign harness_rst_n = hrst_q;
  assign load          = load_q;
  assign tg_start      = tg_q;
  assign load_idx      = idx_q;
  assign point_valid   = pv_q;
  assign point_timeout = pto_q;
  assign point_error   = perr_q;
  assign run_cycles    = runc_q;
  assign busy          = busy_q;
  assign sweep_done    = done_q;

endmodule

// File: tb/tb_axis_load_sweep_ctrl.sv
// Bench for axis_load_sweep_ctrl: a phase-timeline model predicts every output each cycle.
module tb_axis_load_sweep_ctrl;

  localparam int NTG = 4;
  localparam int NL  = 3;
  localparam int LW  = 16;
  localparam int CW  = 32;
  localparam int RC  = 6;
  localparam int SC  = 5;
  localparam int AC  = 6;
  localparam int DC  = 3;
  localparam int TW  = 6;
  localparam int IW  = $clog2(NL);
  localparam int RW  = TW + 1;

  localparam int PhIdle = 0, PhRst = 1, PhSettle = 2, PhArm = 3;
  localparam int PhRun = 4, PhDrain = 5, PhReport = 6, PhDone = 7;

  typedef struct packed {
    logic           hrst;
    logic [LW-1:0]  load;
    logic [NTG-1:0] tg;
    logic [IW-1:0]  idx;
    logic           pv;
    logic           pto;
    logic [NTG-1:0] perr;
    logic [RW-1:0]  runc;
    logic           busy;
    logic           done;
  } outs_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               sweep_start;
  logic [NL*LW-1:0]   load_table;
  logic [NTG-1:0]     tg_done, chk_error;
  logic [CW-1:0]      sum_sent, sum_recv;
  logic               harness_rst_n, point_valid, point_timeout, busy, sweep_done;
  logic [LW-1:0]      load;
  logic [NTG-1:0]     tg_start, point_error;
  logic [IW-1:0]      load_idx;
  logic [RW-1:0]      run_cycles;

  outs_t          got, want;
  int             ph;
  logic [NTG-1:0] acc;
  logic [LW-1:0]  tbl [NL];
  int             dt [NTG];
  int             eqf, errc, sum_fix, pidx, last_r;
  bit             rand_err, cmp_en, pto_p;
  logic [RW-1:0]  runc_p;
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;

  always_comb for (int k = 0; k < NL; k++) load_table[k*LW +: LW] = tbl[k];

  assign got = {harness_rst_n, load, tg_start, load_idx, point_valid, point_timeout,
                point_error, run_cycles, busy, sweep_done};

  axis_load_sweep_ctrl #(
    .NUM_TG(NTG), .NUM_LOADS(NL), .LOAD_WIDTH(LW), .COUNT_WIDTH(CW), .RESET_CYCLES(RC),
    .SETTLE_CYCLES(SC), .ARM_CYCLES(AC), .DRAIN_CYCLES(DC), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sweep_start(sweep_start), .load_table(load_table),
    .tg_done(tg_done), .chk_error(chk_error), .sum_sent(sum_sent), .sum_recv(sum_recv),
    .harness_rst_n(harness_rst_n), .load(load), .tg_start(tg_start), .load_idx(load_idx),
    .point_valid(point_valid), .point_timeout(point_timeout), .point_error(point_error),
    .run_cycles(run_cycles), .busy(busy), .sweep_done(sweep_done)
  );

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cycle_compare t=%0t phase=%0d got=%h required=%h", $time, ph, got, want);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, g, e);
    end
  endtask

  task automatic step(input outs_t nxt, input int nph);
    @(posedge clk);
    want = nxt;
    ph   = nph;
    #1;
  endtask

  task automatic drive_misc();
    chk_error = (rand_err && $urandom_range(0, 5) == 0) ? NTG'($urandom) : '0;
    if (ph == PhArm || ph == PhRun || ph == PhDrain) acc |= chk_error;
    sweep_start = (ph != PhIdle) && (ph != PhDone) && ($urandom_range(0, 7) == 0);
    tg_done  = NTG'($urandom);
    sum_sent = $urandom;
    sum_recv = ($urandom_range(0, 1) == 1) ? sum_sent : $urandom;
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      drive_misc();
      step(want, ph);
    end
  endtask

  task automatic start_sweep();
    outs_t n;
    drive_misc();
    sweep_start = 1'b1;
    n = want;
    n.hrst = 1'b0; n.busy = 1'b1; n.done = 1'b0; n.pv = 1'b0; n.tg = '0;
    n.idx = '0; n.load = tbl[0];
    pidx = 0;
    step(n, PhRst);
  endtask

  task automatic pre_run();
    outs_t n;
    hold(RC - 1);
    drive_misc(); n = want; n.hrst = 1'b1; step(n, PhSettle);
    hold(SC - 1);
    drive_misc(); n = want; n.tg = '1; step(n, PhArm);
    acc = '0;
    hold(AC - 1);
    drive_misc(); step(want, PhRun);
  endtask

  // RUN: completion needs every done bit and equal sums; timeout after 2^TW ARM+RUN cycles
  task automatic run_phase();
    outs_t n;
    int r;
    bit fin;
    logic [CW-1:0] s;
    r = 0;
    fin = 0;
    while (!fin) begin
      drive_misc();
      for (int i = 0; i < NTG; i++) tg_done[i] = (dt[i] >= 0) && (r >= dt[i]);
      if (errc == r) begin
        chk_error = 4'b0100;
        acc |= chk_error;
      end
      s = (sum_fix >= 0) ? CW'(sum_fix) : CW'($urandom);
      sum_sent = s;
      sum_recv = (r >= eqf) ? s : s ^ (CW'(1) << $urandom_range(0, CW - 1));
      n = want;
      n.tg = want.tg & ~tg_done;
      if ((&tg_done) && (r >= eqf)) begin
        fin = 1; pto_p = 1'b0;
      end else if (AC + r + 1 >= (1 << TW)) begin
        fin = 1; pto_p = 1'b1;
      end
      runc_p = RW'(AC + r + 1);
      last_r = r;
      step(n, fin ? PhDrain : PhRun);
      r++;
    end
  endtask

  task automatic do_point();
    outs_t n;
    pre_run();
    run_phase();
    hold(DC - 1);
    drive_misc();
    n = want;
    n.pv = 1'b1; n.pto = pto_p; n.perr = acc; n.runc = runc_p;
    step(n, PhReport);
  endtask

  task automatic advance();
    outs_t n;
    bit stop;
    drive_misc();
    n = want;
    n.pv = 1'b0; n.hrst = 1'b0; n.tg = '0;
    stop = (pidx == NL - 1);
`ifdef AXIS_LOAD_SWEEP_ABORT_ON_ERROR_EN
    if (want.perr != '0) stop = 1;
`endif
    if (stop) begin
      n.busy = 1'b0; n.done = 1'b1;
      step(n, PhDone);
    end else begin
      pidx++;
      n.idx = IW'(pidx); n.load = tbl[pidx];
      step(n, PhRst);
    end
  endtask

  task automatic random_sweep();
    for (int k = 0; k < NL; k++) tbl[k] = LW'($urandom);
    start_sweep();
    for (int p = 0; p < NL; p++) begin
      for (int i = 0; i < NTG; i++) dt[i] = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 40);
      eqf = $urandom_range(0, 45);
      do_point();
      advance();
      if (ph == PhDone) break;
    end
    hold(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    outs_t n;
    rst_n = 1'b0; sweep_start = 1'b0; tg_done = '0; chk_error = '0;
    sum_sent = '0; sum_recv = '0;
    for (int k = 0; k < NL; k++) tbl[k] = '0;
    want = '0; ph = PhIdle; acc = '0; rand_err = 0; errc = -1; sum_fix = -1;
    pidx = 0; last_r = 0; cmp_en = 0;
    #3;
    check("reset_outs_zero", 32'(got != '0), 0);
    check("reset_harness_rst_n", 32'(harness_rst_n), 0);
    cmp_en = 1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    hold(3);

    // Nominal, staggered and tie points
    tbl[0] = 16'h1999; tbl[1] = 16'h0666; tbl[2] = 16'h4000;
    start_sweep();
    check("p0_load", 32'(load), 32'h1999);
    dt = '{20, 20, 20, 20}; eqf = 0; sum_fix = 100;
    do_point();
    check("nominal_drain_at", 32'(last_r), 20);
    check("nominal_runc", 32'(run_cycles), 27);
    advance();
    check("p1_load", 32'(load), 32'h0666);
    check("p1_idx", 32'(load_idx), 1);
    dt = '{3, 7, 9, 15}; eqf = 20; sum_fix = -1;
    do_point();
    check("stagger_drain_at", 32'(last_r), 20);
    check("stagger_runc", 32'(run_cycles), 27);
    advance();
    dt = '{57, 10, 30, 57}; eqf = 57;
    do_point();
    check("tie_timeout", 32'(point_timeout), 0);
    check("tie_runc", 32'(run_cycles), 64);
    advance();
    check("nominal_done", 32'(sweep_done), 1);
    check("nominal_last_idx", 32'(load_idx), 2);
    hold(4);

    // Timeout then error point
    for (int k = 0; k < NL; k++) tbl[k] = LW'($urandom);
    start_sweep();
    dt = '{-1, -1, -1, -1}; eqf = 0;
    do_point();
    check("timeout_flag", 32'(point_timeout), 1);
    check("timeout_runc", 32'(run_cycles), 64);
    advance();
    dt = '{5, 5, 5, 5}; eqf = 0; errc = 2;
    do_point();
    errc = -1;
    check("error_bits", 32'(point_error), 32'h4);
    check("error_no_timeout", 32'(point_timeout), 0);
    advance();
`ifdef AXIS_LOAD_SWEEP_ABORT_ON_ERROR_EN
    check("abort_done", 32'(sweep_done), 1);
    check("abort_idx", 32'(load_idx), 1);
`else
    check("continue_idx", 32'(load_idx), 2);
    dt = '{1, 2, 3, 4}; eqf = 0;
    do_point();
    check("error_cleared", 32'(point_error), 0);
    advance();
`endif
    hold(3);

    rand_err = 1;
    repeat (3) random_sweep();

    // Asynchronous reset in RUN
    start_sweep();
    pre_run();
    repeat (4) begin
      drive_misc();
      tg_done = '0;
      step(want, PhRun);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outs_zero", 32'(got != '0), 0);
    check("async_rst_harness", 32'(harness_rst_n), 0);
    want = '0; ph = PhIdle;
    hold(2);
    #3 rst_n = 1'b1;
    hold(3);

    random_sweep();
    start_sweep();
    check("restart_idx", 32'(load_idx), 0);
    check("restart_busy", 32'(busy), 1);
    for (int p = 0; p < NL; p++) begin
      dt = '{2, 2, 2, 2}; eqf = 0;
      do_point();
      advance();
      if (ph == PhDone) break;
    end
    hold(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
